sdram_arbit: RTL

//  Single arbiter for the SDRAM command bus. Sits between the init, auto-refresh,

---
 rtl/sdram_pkg.sv | 48 ++++
 rtl/sdram_arbit_if.sv | 60 ++++++
 rtl/sdram_arbit_timer.sv | 28 ++
 rtl/sdram_arbit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command-bus arbiter: command encodings,
// arbiter state encoding, default bus widths and the grant priority helper.
package sdram_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int BA_W_DEF   = 2;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_MREG      = 4'b0000;
  localparam logic [3:0] CMD_AREF      = 4'b0001;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_BSTOP     = 4'b0110;
  localparam logic [3:0] CMD_NOP       = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_AREF  = 2'd1,
    GNT_WRITE = 2'd2,
    GNT_READ  = 2'd3
  } grant_t;

  // Refresh always wins; write beats read unless wr_first is low and a read
  // is also waiting (wr_first is tied high when fairness is compiled out).
  function automatic grant_t pick_grant(input logic aref, input logic wr,
                                        input logic rd, input logic wr_first);
    grant_t g;
    g = GNT_NONE;
    if (aref)
      g = GNT_AREF;
    else if (wr && (!rd || wr_first))
      g = GNT_WRITE;
    else if (rd)
      g = GNT_READ;
    return g;
  endfunction

endpackage

// File: rtl/sdram_arbit_if.sv
// Engine-side and SDRAM-pin-side signals of the command-bus arbiter.
// slave: the arbiter; master: the engines / environment driving it.
interface sdram_arbit_if
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BA_W   = BA_W_DEF
) ();

  logic              init_end;
  logic [3:0]        init_cmd;
  logic [BA_W-1:0]   init_ba;
  logic [ADDR_W-1:0] init_addr;

  logic              aref_req;
  logic              aref_end;
  logic [3:0]        aref_cmd;
  logic [BA_W-1:0]   aref_ba;
  logic [ADDR_W-1:0] aref_addr;

  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [BA_W-1:0]   wr_ba;
  logic [ADDR_W-1:0] wr_addr;

  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [BA_W-1:0]   rd_ba;
  logic [ADDR_W-1:0] rd_addr;

  logic              aref_en;
  logic              wr_en;
  logic              rd_en;
  logic              sdram_cke;
  logic [3:0]        sdram_cmd;
  logic [BA_W-1:0]   sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic              op_timeout;

  modport slave (
    input  init_end, init_cmd, init_ba, init_addr,
    input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
    input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    output aref_en, wr_en, rd_en,
    output sdram_cke, sdram_cmd, sdram_ba, sdram_addr, op_timeout
  );

  modport master (
    output init_end, init_cmd, init_ba, init_addr,
    output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
    output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    input  aref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cmd, sdram_ba, sdram_addr, op_timeout
  );

endinterface

// File: rtl/sdram_arbit_timer.sv
// Operation watchdog: clear/enable counter with a terminal-count flag that
// fires on the last allowed cycle of an operation (count == OP_TIMEOUT-1).
module sdram_arbit_timer #(
  parameter int OP_TIMEOUT = 1023,
  localparam int CNT_W     = $clog2(OP_TIMEOUT + 1)
) (
  input  logic i_sysclk,
  input  logic i_sysrst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(OP_TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  // Count cycles while enabled; held at zero whenever cleared.
  always_ff @(posedge i_sysclk) begin
    if (!i_sysrst_n || clr)
      count_reg <= '0;
    else if (en)
      count_reg <= count_reg + CNT_W'(1);
  end

  assign tc = en && (count_reg == TC_VAL);

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: muxes the init, refresh, write and read engines
// onto the SDRAM pins with priority refresh > write > read and a watchdog
// that aborts any operation lasting OP_TIMEOUT cycles.
// Optional: define SDRAM_ARBIT_FAIR_EN to alternate write/read when both wait.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int BA_W       = BA_W_DEF,
  parameter int OP_TIMEOUT = 1023
) (
  input  logic          i_sysclk,
  input  logic          i_sysrst_n,
  sdram_arbit_if.slave  bus
);

  arb_state_t        state_reg;
  logic              aref_en_reg;
  logic              wr_en_reg;
  logic              rd_en_reg;
  logic              op_timeout_reg;

  logic              op_active;
  logic              end_match;
  logic              timer_tc;
  logic              wr_first;
  grant_t            grant;

  logic [3:0]        cmd_mux;
  logic [BA_W-1:0]   ba_mux;
  logic [ADDR_W-1:0] addr_mux;

`ifdef SDRAM_ARBIT_FAIR_EN
  logic last_wr_reg;
  assign wr_first = ~last_wr_reg;
`else
  assign wr_first = 1'b1;
`endif

  assign op_active = (state_reg == ST_AREF) || (state_reg == ST_WRITE) ||
                     (state_reg == ST_READ);
  assign grant     = pick_grant(bus.aref_req, bus.wr_req, bus.rd_req, wr_first);

  // Timer is held at zero outside op states, so it starts from 0 on entry.
  sdram_arbit_timer #(
    .OP_TIMEOUT (OP_TIMEOUT)
  ) u_timer (
    .i_sysclk   (i_sysclk),
    .i_sysrst_n (i_sysrst_n),
    .clr        (~op_active),
    .en         (op_active),
    .tc         (timer_tc)
  );

  // Only the active engine's done pulse ends the current operation.
  always_comb begin
    end_match = 1'b0;
    case (state_reg)
      ST_AREF:  end_match = bus.aref_end;
      ST_WRITE: end_match = bus.wr_end;
      ST_READ:  end_match = bus.rd_end;
      default:  end_match = 1'b0;
    endcase
  end

  // Arbiter FSM with registered one-cycle grants and the sticky timeout flag.
  always_ff @(posedge i_sysclk) begin
    if (!i_sysrst_n) begin
      state_reg      <= ST_IDLE;
      aref_en_reg    <= 1'b0;
      wr_en_reg      <= 1'b0;
      rd_en_reg      <= 1'b0;
      op_timeout_reg <= 1'b0;
`ifdef SDRAM_ARBIT_FAIR_EN
      last_wr_reg    <= 1'b0;
`endif
    end else begin
      aref_en_reg <= 1'b0;
      wr_en_reg   <= 1'b0;
      rd_en_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.init_end)
            state_reg <= ST_ARBIT;
        end
        ST_ARBIT: begin
          case (grant)
            GNT_AREF: begin
              state_reg   <= ST_AREF;
              aref_en_reg <= 1'b1;
            end
            GNT_WRITE: begin
              state_reg <= ST_WRITE;
              wr_en_reg <= 1'b1;
`ifdef SDRAM_ARBIT_FAIR_EN
              last_wr_reg <= 1'b1;
`endif
            end
            GNT_READ: begin
              state_reg <= ST_READ;
              rd_en_reg <= 1'b1;
`ifdef SDRAM_ARBIT_FAIR_EN
              last_wr_reg <= 1'b0;
`endif
            end
            default: ;
          endcase
        end
        ST_AREF, ST_WRITE, ST_READ: begin
          // A done pulse on the terminal cycle is a normal finish.
          if (end_match) begin
            state_reg <= ST_ARBIT;
          end else if (timer_tc) begin
            state_reg      <= ST_ARBIT;
            op_timeout_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Pin mux: init engine while idle, the owning engine during an op, NOP otherwise.
  always_comb begin
    cmd_mux  = CMD_NOP;
    ba_mux   = '0;
    addr_mux = '0;
    case (state_reg)
      ST_IDLE: begin
        cmd_mux  = bus.init_cmd;
        ba_mux   = bus.init_ba;
        addr_mux = bus.init_addr;
      end
      ST_AREF: begin
        cmd_mux  = bus.aref_cmd;
        ba_mux   = bus.aref_ba;
        addr_mux = bus.aref_addr;
      end
      ST_WRITE: begin
        cmd_mux  = bus.wr_cmd;
        ba_mux   = bus.wr_ba;
        addr_mux = bus.wr_addr;
      end
      ST_READ: begin
        cmd_mux  = bus.rd_cmd;
        ba_mux   = bus.rd_ba;
        addr_mux = bus.rd_addr;
      end
      default: begin
        cmd_mux  = CMD_NOP;
        ba_mux   = '0;
        addr_mux = '0;
      end
    endcase
  end

  assign bus.aref_en    = aref_en_reg;
  assign bus.wr_en      = wr_en_reg;
  assign bus.rd_en      = rd_en_reg;
  assign bus.op_timeout = op_timeout_reg;
  assign bus.sdram_cke  = 1'b1;
  assign bus.sdram_cmd  = cmd_mux;
  assign bus.sdram_ba   = ba_mux;
  assign bus.sdram_addr = addr_mux;

endmodule
